// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared width and operation-select constants for the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int   ALU_W   = 8;
    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_SUB = 1'b1;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : One-bit full-adder cell; one link of the ripple-carry chain.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder
`default_nettype wire

// File: rtl/alu_sch.sv
`default_nettype none
// ============================================================================
// Module      : alu_sch
// Description : Ripple-carry add/subtract ALU with registered result and carry.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sch
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             SEL,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             Cnext
);

    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] r_data;
    logic             r_carry;

    // Subtract is X + ~Y + 1: invert B and feed the +1 through the carry-in.
    assign w_b    = Y ^ {WIDTH{SEL}};
    assign w_c[0] = (SEL == SEL_SUB);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            full_adder u_fa (
                .a    (X[gi]),
                .b    (w_b[gi]),
                .cin  (w_c[gi]),
                .s    (w_sum[gi]),
                .cout (w_c[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_data  <= '0;
            r_carry <= 1'b0;
        end else begin
            r_data  <= w_sum;
            r_carry <= w_c[WIDTH];
        end
    end

    assign DATA_OUT = r_data;
    assign Cnext    = r_carry;

endmodule : alu_sch
`default_nettype wire

// File: tb/tb_alu_sch.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sch
// Description : Scoreboard bench for alu_sch against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sch;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         s;
        logic [W-1:0] d;
        logic         c;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [W-1:0] X = '0;
    logic [W-1:0] Y = '0;
    logic         SEL = 1'b0;
    logic [W-1:0] DATA_OUT;
    logic         Cnext;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    alu_sch #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .X        (X),
        .Y        (Y),
        .SEL      (SEL),
        .DATA_OUT (DATA_OUT),
        .Cnext    (Cnext)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s);
        exp_t e;
        int   xi = int'(x);
        int   yi = int'(y);
        int   m  = 1 << W;
        e.x = x; e.y = y; e.s = s;
        if (s) begin
            e.d = W'((xi - yi + m) % m);
            e.c = (xi >= yi);
        end else begin
            e.d = W'((xi + yi) % m);
            e.c = ((xi + yi) >= m);
        end
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        @(negedge CLK);
        X = x; Y = y; SEL = s;
        sb_q.push_back(model(x, y, s));
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if (DATA_OUT !== '0 || Cnext !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got data=%h carry=%b, want data=00 carry=0",
                     name, DATA_OUT, Cnext);
        end
    endtask

    // Monitor: one result per edge, compared against the oldest issued op.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_tests++;
                if (DATA_OUT !== e.d || Cnext !== e.c) begin
                    n_fail++;
                    $display("FAIL op x=%h y=%h sel=%b: got data=%h carry=%b, want data=%h carry=%b",
                             e.x, e.y, e.s, DATA_OUT, Cnext, e.d, e.c);
                end
            end
        end
    end

    initial begin
        #1;
        check_zero("reset_initial");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        issue(8'hAA, 8'h55, 1'b0);
        @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        check_zero("reset_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            check_zero("reset_hold");
        end
        @(negedge CLK);
        RST_N = 1'b1;
        sb_q.push_back(model(8'hAA, 8'h55, 1'b0));
        #1;
        check_zero("reset_release_pre_edge");

        issue(8'h11, 8'h11, 1'b0);
        issue(8'h11, 8'h11, 1'b1);
        issue(8'hAA, 8'h55, 1'b0);
        issue(8'hAA, 8'h55, 1'b1);
        issue(8'hFF, 8'h01, 1'b0);
        issue(8'hFF, 8'h01, 1'b1);
        issue(8'h01, 8'h02, 1'b1);
        issue(8'h00, 8'h00, 1'b0);
        issue(8'h00, 8'h00, 1'b1);
        issue(8'hFF, 8'hFF, 1'b0);
        issue(8'h00, 8'hFF, 1'b1);
        issue(8'h80, 8'h80, 1'b0);

        for (int i = 0; i < 256; i++)
            issue(W'($urandom), W'($urandom), 1'($urandom));

        repeat (3) @(negedge CLK);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_sch
`default_nettype wire
